// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and sends them LSB first.
// Optional even-parity bit between data and stop when FIFO_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
`endif

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [15:0]       baud_reg, baud_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [7:0]        frame_cnt_reg, frame_cnt_next;
    logic              tx_reg, tx_next;
    logic              baud_done;
`ifdef FIFO_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            baud_reg      <= '0;
            bit_reg       <= '0;
            frame_cnt_reg <= '0;
            tx_reg        <= 1'b1;
`ifdef FIFO_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            baud_reg      <= baud_next;
            bit_reg       <= bit_next;
            frame_cnt_reg <= frame_cnt_next;
            tx_reg        <= tx_next;
`ifdef FIFO_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    assign baud_done = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        baud_next      = baud_reg;
        bit_next       = bit_reg;
        frame_cnt_next = frame_cnt_reg;
        fifo_read      = 1'b0;
        tx_next        = 1'b1;
`ifdef FIFO_TX_PARITY_EN
        parity_next    = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Strobe is gated by rst so no pop can leak out while held in reset
                if (!fifo_empty) begin
                    fifo_read  = !rst;
                    state_next = REQ;
                end
            end
            REQ: state_next = LOAD;
            LOAD: begin
                shift_next = fifo_dout;
                baud_next  = '0;
                bit_next   = '0;
`ifdef FIFO_TX_PARITY_EN
                parity_next = ^fifo_dout;
`endif
                state_next = START;
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next = '0;
`ifdef FIFO_TX_PARITY_EN
                        state_next = PAR;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PAR: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next      = '0;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    state_next     = IDLE;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so the line never glitches
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_TX_PARITY_EN
            PAR:     tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign tx        = tx_reg;
    assign busy      = fifo_read | (state_reg != IDLE);
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: a queue-based FIFO feeds the DUT and a frame-level
// model predicts tx, busy, fifo_read and frame_cnt every cycle.
module tb_fifo_uart_tx;
    localparam int CPB    = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_read;
    logic              tx;
    logic              busy;
    logic [7:0]        frame_cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .tx         (tx),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    logic [DATA_W-1:0] fifo_q[$];
    exp_t              exp_q[$];
    logic [7:0]        exp_cnt = 8'd0;
    logic [DATA_W-1:0] cur_word;
    int                n_tests = 0;
    int                n_fail = 0;
    int                frames_done = 0;
    int                rd_pulses = 0;
    int                hold = 0;
    logic              junk_en = 1'b0;
    logic              junk_dead = 1'b0;
    logic              rd_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line waveform for one frame, starting with the REQ and LOAD cycles
    task automatic push_frame(input logic [DATA_W-1:0] w);
        exp_t e;
        e.last = 1'b0;
        e.tx = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        e.tx = 1'b0;
        for (int k = 0; k < CPB; k++) exp_q.push_back(e);
        for (int b = 0; b < DATA_W; b++) begin
            e.tx = w[b];
            for (int k = 0; k < CPB; k++) exp_q.push_back(e);
        end
`ifdef FIFO_TX_PARITY_EN
        e.tx = ^w;
        for (int k = 0; k < CPB; k++) exp_q.push_back(e);
`endif
        e.tx = 1'b1;
        for (int k = 0; k < CPB - 1; k++) exp_q.push_back(e);
        e.last = 1'b1;
        exp_q.push_back(e);
        cur_word = w;
    endtask

    task automatic model_check();
        exp_t e;
        logic nonempty;
        if (rst) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_read", fifo_read, 0);
            check("rst_cnt", frame_cnt, 0);
            exp_q.delete();
            exp_cnt = 8'd0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx", tx, e.tx);
            check("busy", busy, 1);
            check("read_in_frame", fifo_read, 0);
            check("frame_cnt", frame_cnt, exp_cnt);
            if (e.last) begin
                exp_cnt++;
                frames_done++;
                $display("[TB] frame %0d complete, word %h, frame_cnt now %0d", frames_done, cur_word, exp_cnt);
            end
        end else begin
            nonempty = (fifo_q.size() > 0);
            check("idle_tx", tx, 1);
            check("idle_busy", busy, nonempty);
            check("idle_read", fifo_read, nonempty);
            check("frame_cnt", frame_cnt, exp_cnt);
            if (nonempty) push_frame(fifo_q[0]);
        end
    endtask

    // One clock: check at negedge, then act as a registered-output FIFO just after posedge
    task automatic cycle();
        @(negedge clk);
        model_check();
        rd_seen = fifo_read;
        if (rd_seen) rd_pulses++;
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            hold = 2;
        end else begin
            if (hold > 0) hold--;
            if (hold == 0 && junk_en) fifo_dout = junk_dead ? 16'hDEAD : DATA_W'($urandom);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && k < max_cycles) begin
            cycle();
            k++;
        end
        check("drain_timeout", (k < max_cycles), 1);
        repeat (4) cycle();
    endtask

    initial begin
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        repeat (5) cycle();
        rst = 1'b0;
        repeat (200) cycle();
        check("idle_no_reads", rd_pulses, 0);

        // single word, line junk on fifo_dout once captured
        junk_en = 1'b1;
        junk_dead = 1'b1;
        push(16'h00A5);
        drain(200);
        check("a5_reads", rd_pulses, 1);
        check("a5_cnt", frame_cnt, 1);

        // burst of words, back-to-back frames
        junk_dead = 1'b0;
        push(16'h0011);
        push(16'h0012);
        push(16'h0013);
        push(16'h0001);
        push(16'h0003);
        drain(600);
        check("burst_cnt", frame_cnt, 6);
        check("burst_reads", rd_pulses, 6);
        repeat (40) cycle();
        check("no_extra_reads", rd_pulses, 6);

        // reset 30 cycles into a frame, next word must go out intact
        push(16'hFFFF);
        push(16'h1234);
        repeat (33) cycle();
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_cnt", frame_cnt, 0);
        repeat (3) cycle();
        rst = 1'b0;
        drain(200);
        check("after_rst_cnt", frame_cnt, 1);
        check("after_rst_reads", rd_pulses, 8);

        // reset during the start bit, line must return high at once
        push(16'h00F0);
        repeat (5) cycle();
        check("start_bit_low", tx, 0);
        rst = 1'b1;
        #1;
        check("async_rst_start", tx, 1);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();

        // random traffic with sporadic empty periods
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2 && fifo_q.size() < 3) push(DATA_W'($urandom));
            cycle();
        end
        drain(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, SHALL set the clk cycles per serial bit; legal values are 2 to 65535.
REQ-002 Parameter DATA_W, default 16, SHALL set the FIFO word width and the number of data bits per frame.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 fifo_dout  input  DATA_W  SHALL carry the word popped from the upstream FIFO.
REQ-006 fifo_empty  input  1  SHALL indicate, when high, that the upstream FIFO holds no word.
REQ-007 fifo_read  output  1  SHALL be a one-cycle pop strobe to the upstream FIFO.
REQ-008 tx  output  1  SHALL be the serial line, idling high.
REQ-009 busy  output  1  SHALL be high from the fifo_read pulse until the end of the stop bit.
REQ-010 frame_cnt  output  8  SHALL count completed frames, wrapping from 255 to 0.

Function
REQ-011 The FSM SHALL have the states IDLE, REQ, LOAD, START, DATA, PAR and STOP.
REQ-012 IDLE: if fifo_empty is low, the block SHALL assert fifo_read for exactly one cycle and go to REQ; otherwise it SHALL stay in IDLE.
REQ-013 REQ: the block SHALL wait one cycle for pop latency and go to LOAD; fifo_dout SHALL be valid in the cycle after fifo_read.
REQ-014 LOAD: the block SHALL capture fifo_dout into the shift register, clear the bit and baud counters, and go to START.
REQ-015 START: tx SHALL be 0 for CLKS_PER_BIT cycles.
REQ-016 DATA: the block SHALL transmit DATA_W bits LSB first, each held for CLKS_PER_BIT cycles, and go to PAR if parity is enabled, otherwise to STOP.
REQ-017 STOP: tx SHALL be 1 for CLKS_PER_BIT cycles; frame_cnt SHALL then increment and the FSM SHALL return to IDLE.
REQ-018 With the FIFO non-empty, back-to-back frames SHALL be separated by exactly 3 idle-high cycles (IDLE, REQ, LOAD).
REQ-019 fifo_read SHALL never assert while fifo_empty is high, nor outside IDLE.
REQ-020 The captured word SHALL be immune to changes on fifo_dout after LOAD.
REQ-021 A rise of fifo_empty mid-frame SHALL NOT affect the current frame.
REQ-022 The baud counter SHALL be 16 bits wide and count 0 to CLKS_PER_BIT-1; the bit counter SHALL be ceil(log2(DATA_W+1)) bits wide.
REQ-023 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles without parity and (DATA_W+3)*CLKS_PER_BIT cycles with parity.

Reset
REQ-024 While rst is high, the state SHALL be IDLE, with tx=1, fifo_read=0, busy=0, frame_cnt=0, and the shift register and counters cleared, independent of clk.
REQ-025 A reset asserted mid-frame SHALL abort the frame immediately, with tx returning to 1; the aborted frame SHALL NOT be counted and the word SHALL NOT be re-read.
REQ-026 After rst deasserts, the first fifo_read SHALL occur no earlier than the first rising edge following deassertion.

Configuration
REQ-027 Macro FIFO_TX_PARITY_EN SHALL control the parity feature.
REQ-028 With FIFO_TX_PARITY_EN defined, PAR SHALL transmit the even-parity bit (XOR of the DATA_W data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-029 Without FIFO_TX_PARITY_EN, the PAR state and the parity logic SHALL be absent and DATA SHALL go directly to STOP.

Verification
REQ-030 Reset with fifo_empty=1 held for 200 cycles -> tx=1, fifo_read=0, busy=0, frame_cnt=0 throughout.
REQ-031 One word 16'h00A5, CLKS_PER_BIT=4, no parity -> one fifo_read pulse; tx sequence 0, 1010010100000000 (LSB first), 1; each bit 4 cycles; 72 cycles total; frame_cnt=1.
REQ-032 Words 16'h0011, 16'h0012, 16'h0013 queued -> three frames with exactly 3 idle cycles between them; frame_cnt=3; after the third, fifo_empty=1 and no further fifo_read.
REQ-033 FIFO_TX_PARITY_EN defined, words 16'h0001 and 16'h0003 -> parity bits 1 and 0 respectively; each frame 76 cycles.
REQ-034 rst pulsed at cycle 30 of a 16'hFFFF frame -> tx=1 immediately; frame_cnt=0; the next queued word 16'h1234 transmits in full after release.
REQ-035 fifo_dout changed to 16'hDEAD during DATA -> the transmitted bits still match the word captured in LOAD.
